host_mem_responder: RTL and testbench
=====================================

# host_mem_responder

Host-side responder for the line-based DMA interface driven by the memory controller. It sits where the host memory shim normally sits, so the controller can run end to end in simulation and on the FPGA without the host. It accepts read bursts (`rd_go`) and write bursts (`wr_go`) of 512-bit cache lines and serves them from an internal backing RAM. Reads are returned through a first-word-fall-through FIFO; writes are absorbed through a bounded write FIFO.

## Interface
- `ADDR_W`, 8: line-index bits; backing RAM holds 2^ADDR_W lines of 512 b.
- `FIFO_DEPTH`, 4: entries in each of the read and write FIFOs (power of 2, ≥2).
- `RD_LATENCY`, 4: minimum cycles from `rd_go` to first line visible (≥2).
- `WR_LATENCY`, 2: cycles from last RAM commit to `wr_done` (≥1).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `rd_go` in 1: start read burst; sampled only in R_IDLE.
- `rd_addr` in 64: byte address; line index = `rd_addr[ADDR_W+5:6]`, other bits ignored.
- `cache_lines` in 16: burst length in lines, latched on `rd_go`.
- `rd_en` in 1: pop read FIFO head; ignored when `empty`.
- `rd_data` out 512: read FIFO head; 0 when `empty`.
- `empty` out 1: read FIFO empty.
- `rd_done` out 1: 1-cycle pulse, read burst complete.
- `wr_go` in 1: start write burst; sampled only in W_IDLE.
- `wr_addr` in 64: byte address, decoded as for `rd_addr`.
- `wr_size` in 16: burst length in lines, latched on `wr_go`.
- `wr_en` in 1: push `wr_data`; accepted only when `~full`.
- `wr_data` in 512: write line.
- `full` out 1: write side cannot accept.
- `wr_done` out 1: 1-cycle pulse, write burst committed.

## Operation
- Read FSM: R_IDLE -> R_WAIT on `rd_go`; latch base index, count.
  - R_WAIT counts down RD_LATENCY-2, then -> R_STREAM.
  - R_STREAM issues one synchronous RAM read per cycle while FIFO has space (counting in-flight reads), incrementing index mod 2^ADDR_W. After `count` issues -> R_DRAIN.
  - R_DRAIN -> R_IDLE when the last line is popped; `rd_done` pulses the next cycle.
- Write FSM: W_IDLE -> W_ACCEPT on `wr_go`; latch base index, count.
  - Accept `wr_en & ~full` into the write FIFO. A non-empty write FIFO drains one line per cycle into RAM at base + commit_count, wrapping mod 2^ADDR_W.
  - After `count` commits -> W_COMMIT, which counts WR_LATENCY, pulses `wr_done` and returns to W_IDLE.
- `full` = 1 in W_IDLE, W_COMMIT, when the write FIFO is full, or once `count` lines have been accepted. Extra `wr_en` pulses are dropped.
- Length 0: read -> R_IDLE, with `rd_done` 1 cycle after `rd_go` and no data. Write -> W_COMMIT immediately.
- Read and write FSMs are independent and may run concurrently. A same-line RAM read and write in the same cycle returns the old data (read-first).
- `rd_go` / `wr_go` outside their idle state are ignored.
- Reset outputs: `empty`=1, `full`=1, `rd_done`=0, `wr_done`=0, `rd_data`=0. Both FSMs go to idle and both FIFOs are flushed.
- Reset mid-burst aborts the burst with no done pulse. RAM contents are not cleared by reset.

## Timing
- `rd_go` in cycle 0 -> `empty` low no earlier than cycle RD_LATENCY (exactly RD_LATENCY when the FIFO is free).
- With `rd_en` held high, one line is delivered per cycle and `rd_done` pulses the cycle after the final pop.
- Write line accepted in cycle t, with no FIFO backlog -> RAM commit in t+1.
- Last commit in cycle c -> `wr_done` in c+WR_LATENCY.
- `full` / `empty` are registered-state derived; no combinational path from `rd_en`/`wr_en` to `full`/`empty`.

## Structure
- Package `host_mem_pkg`:
  - `LINE_W`=512.
  - `rd_state_t` {R_IDLE, R_WAIT, R_STREAM, R_DRAIN}.
  - `wr_state_t` {W_IDLE, W_ACCEPT, W_COMMIT}.
- Sub-module `line_fifo` (params WIDTH, DEPTH): synchronous FWFT FIFO with count output, instantiated twice.
- Backing RAM: inferred in the top level, 1 write port and 1 read port.

## Test plan
- Reset, then idle 10 cycles -> `empty`=1, `full`=1, `rd_data`=0, no done pulses.
- Write 4 lines to addr 0x0 holding values 0xA0..0xA3, with `wr_en` held high -> exactly 4 accepted. `wr_done` pulses 1+WR_LATENCY cycles after the 4th accept.
- Read 4 lines from 0x0 with `rd_en`=~empty -> first line at cycle 4, then 0xA0..0xA3 on consecutive cycles. `rd_done` pulses the cycle after the 4th pop.
- Read 8 lines from line 254 (ADDR_W=8) with `rd_en` held low for 10 cycles -> `empty` low, no overflow. Lines come from 254, 255, 0..5 in order.
- Write and read bursts on disjoint addresses started in the same cycle -> both complete with correct data, and each done pulse is seen exactly once.
- Assert `rst` mid-read after 2 pops -> no `rd_done`, `empty`=1 next cycle. A re-read returns the RAM data unchanged.

Source files
------------

// File: rtl/host_mem_pkg.sv
// Shared types and constants for the host-side DMA memory responder.
package host_mem_pkg;

  localparam int LINE_W = 512;
  localparam int LEN_W  = 16;
  localparam int TMR_W  = 8;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_STREAM, R_DRAIN} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_COMMIT} wr_state_t;

endpackage

// File: rtl/line_fifo.sv
// First-word-fall-through line FIFO; head is visible whenever the FIFO is non-empty.
module line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign dout_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;

endmodule

// File: rtl/host_mem_responder.sv
// Stand-in for the host memory shim: serves line bursts from an internal RAM.
//   state    | meaning
//   R_IDLE   | waiting for rd_go
//   R_WAIT   | modelling host read latency
//   R_STREAM | one RAM read per cycle into the read FIFO while it has room
//   R_DRAIN  | all lines issued, waiting for the last pop
//   W_IDLE   | waiting for wr_go
//   W_ACCEPT | taking lines into the write FIFO and committing them to RAM
//   W_COMMIT | modelling write-acknowledge latency before wr_done
module host_mem_responder
  import host_mem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_go,
  input  logic [63:0]       rd_addr,
  input  logic [15:0]       cache_lines,
  input  logic              rd_en,
  output logic [LINE_W-1:0] rd_data,
  output logic              empty,
  output logic              rd_done,
  input  logic              wr_go,
  input  logic [63:0]       wr_addr,
  input  logic [15:0]       wr_size,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_data,
  output logic              full,
  output logic              wr_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;
  logic [TMR_W-1:0]  rd_tmr_q, rd_tmr_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_issue, rd_pop;

  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]  wr_acc_left_q, wr_acc_left_d;
  logic [LEN_W-1:0]  wr_com_left_q, wr_com_left_d;
  logic [TMR_W-1:0]  wr_tmr_q, wr_tmr_d;
  logic              wr_accept, wr_commit;

  logic [LINE_W-1:0] rf_dout, wf_dout, ram_rd;
  logic              rf_empty, rf_full, wf_empty, wf_full;
  logic [CNT_W-1:0]  rf_count, wf_count;
  logic              unused_ok;

  logic [LINE_W-1:0] mem_q [2**ADDR_W];

  // Read-first: the combinational read sees the value before this cycle's commit.
  assign ram_rd = mem_q[rd_idx_q];

  always_ff @(posedge clk) begin
    if (wr_commit) mem_q[wr_idx_q] <= wf_dout;
  end

  line_fifo #(.WIDTH(LINE_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_issue),
    .din_i   (ram_rd),
    .pop_i   (rd_pop),
    .dout_o  (rf_dout),
    .empty_o (rf_empty),
    .full_o  (rf_full),
    .count_o (rf_count)
  );

  line_fifo #(.WIDTH(LINE_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_accept),
    .din_i   (wr_data),
    .pop_i   (wr_commit),
    .dout_o  (wf_dout),
    .empty_o (wf_empty),
    .full_o  (wf_full),
    .count_o (wf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q    <= R_IDLE;
      rd_idx_q      <= '0;
      rd_left_q     <= '0;
      rd_tmr_q      <= '0;
      rd_done_q     <= 1'b0;
      wr_state_q    <= W_IDLE;
      wr_idx_q      <= '0;
      wr_acc_left_q <= '0;
      wr_com_left_q <= '0;
      wr_tmr_q      <= '0;
    end else begin
      rd_state_q    <= rd_state_d;
      rd_idx_q      <= rd_idx_d;
      rd_left_q     <= rd_left_d;
      rd_tmr_q      <= rd_tmr_d;
      rd_done_q     <= rd_done_d;
      wr_state_q    <= wr_state_d;
      wr_idx_q      <= wr_idx_d;
      wr_acc_left_q <= wr_acc_left_d;
      wr_com_left_q <= wr_com_left_d;
      wr_tmr_q      <= wr_tmr_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_left_d  = rd_left_q;
    rd_tmr_d   = rd_tmr_q;
    rd_done_d  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (rd_go) begin
          rd_idx_d  = rd_addr[ADDR_W+5:6];
          rd_left_d = cache_lines;
          rd_tmr_d  = TMR_W'(RD_LATENCY - 2);
          if (cache_lines == '0)   rd_done_d  = 1'b1;
          else if (RD_LATENCY == 2) rd_state_d = R_STREAM;
          else                     rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rd_tmr_d = rd_tmr_q - TMR_W'(1);
        if (rd_tmr_q == TMR_W'(1)) rd_state_d = R_STREAM;
      end
      R_STREAM: begin
        if (rd_issue) begin
          rd_idx_d  = rd_idx_q + ADDR_W'(1);
          rd_left_d = rd_left_q - LEN_W'(1);
          if (rd_left_q == LEN_W'(1)) rd_state_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (rd_pop && rf_count == CNT_W'(1)) begin
          rd_state_d = R_IDLE;
          rd_done_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (rd_state_q == R_STREAM) & ~rf_full;
    rd_pop   = rd_en & ~rf_empty;
    empty    = rf_empty;
    rd_data  = rf_empty ? '0 : rf_dout;
    rd_done  = rd_done_q;
  end

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_idx_d      = wr_idx_q;
    wr_acc_left_d = wr_acc_left_q;
    wr_com_left_d = wr_com_left_q;
    wr_tmr_d      = wr_tmr_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (wr_go) begin
          wr_idx_d      = wr_addr[ADDR_W+5:6];
          wr_acc_left_d = wr_size;
          wr_com_left_d = wr_size;
          wr_tmr_d      = TMR_W'(WR_LATENCY);
          wr_state_d    = (wr_size == '0) ? W_COMMIT : W_ACCEPT;
        end
      end
      W_ACCEPT: begin
        wr_tmr_d = TMR_W'(WR_LATENCY);
        if (wr_accept) wr_acc_left_d = wr_acc_left_q - LEN_W'(1);
        if (wr_commit) begin
          wr_idx_d      = wr_idx_q + ADDR_W'(1);
          wr_com_left_d = wr_com_left_q - LEN_W'(1);
          if (wr_com_left_q == LEN_W'(1)) wr_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        wr_tmr_d = wr_tmr_q - TMR_W'(1);
        if (wr_tmr_q == TMR_W'(1)) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    full      = (wr_state_q != W_ACCEPT) | wf_full | (wr_acc_left_q == '0);
    wr_accept = wr_en & ~full;
    wr_commit = (wr_state_q == W_ACCEPT) & ~wf_empty;
    wr_done   = (wr_state_q == W_COMMIT) & (wr_tmr_q == TMR_W'(1));
  end

  assign unused_ok = ^{rd_addr[63:ADDR_W+6], rd_addr[5:0],
                       wr_addr[63:ADDR_W+6], wr_addr[5:0], wf_count};

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder: per-cycle vector table plus burst sequences.
module tb_host_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_go, rd_en, wr_go, wr_en;
  logic [63:0]  rd_addr, wr_addr;
  logic [15:0]  cache_lines, wr_size;
  logic [511:0] rd_data, wr_data;
  logic         empty, rd_done, full, wr_done;

  int checks = 0;
  int errors = 0;
  int acc_n, rd_done_n, wr_done_n, pops;
  logic [511:0] got_q[$];
  logic [511:0] exp_d;

  typedef struct {
    bit rd_go; int rd_line; int rd_len; bit rd_en;
    bit wr_go; int wr_line; int wr_len; bit wr_en; int wr_val;
    bit e_empty; bit e_full; bit e_rd_done; bit e_wr_done; int e_data;
  } vec_t;
  vec_t tbl[$];

  host_mem_responder #(.ADDR_W(8), .FIFO_DEPTH(4), .RD_LATENCY(4), .WR_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .rd_go(rd_go), .rd_addr(rd_addr), .cache_lines(cache_lines), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  function automatic logic [63:0] addr(int l);
    return (64'(l) << 6) | 64'h0000_0100_0000_0025;
  endfunction

  function automatic logic [511:0] line(int v);
    return {16{32'(v)}};
  endfunction

  function automatic vec_t v(bit rg, int rl, int rn, bit re, bit wg, int wl, int wn, bit we,
                             int wv, bit ee, bit ef, bit erd, bit ewd, int ed);
    vec_t r;
    r.rd_go = rg; r.rd_line = rl; r.rd_len = rn; r.rd_en = re;
    r.wr_go = wg; r.wr_line = wl; r.wr_len = wn; r.wr_en = we; r.wr_val = wv;
    r.e_empty = ee; r.e_full = ef; r.e_rd_done = erd; r.e_wr_done = ewd; r.e_data = ed;
    return r;
  endfunction

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs a read and/or write burst with rd_en = ~empty and wr_en held high,
  // feeding consecutive data values on each accepted write.
  task automatic run_bursts(input bit do_wr, input int wl, input int wn, input int wv,
                            input bit do_rd, input int rl, input int rn, input int max_cyc);
    int tail;
    tail = -1; acc_n = 0; rd_done_n = 0; wr_done_n = 0;
    got_q.delete();
    for (int c = 0; c < max_cyc && tail != 0; c++) begin
      @(negedge clk);
      if (rd_done) rd_done_n++;
      if (wr_done) wr_done_n++;
      rd_go = (c == 0) && do_rd; rd_addr = addr(rl); cache_lines = 16'(rn);
      wr_go = (c == 0) && do_wr; wr_addr = addr(wl); wr_size = 16'(wn);
      rd_en = do_rd && !empty;
      if (rd_en) got_q.push_back(rd_data);
      wr_en = do_wr;
      if (do_wr && !full) begin
        wr_data = line(wv + acc_n);
        acc_n++;
      end else begin
        wr_data = line(32'hDEAD);
      end
      if (tail > 0) tail--;
      else if (tail < 0 && (!do_rd || rd_done_n > 0) && (!do_wr || wr_done_n > 0)) tail = 3;
    end
    rd_go = 0; wr_go = 0; rd_en = 0; wr_en = 0;
    chk("burst_timeout", 512'(tail != 0), 512'(0));
  endtask

  task automatic chk_reads(string nm, int n, int base);
    chk({nm, "_count"}, 512'(got_q.size()), 512'(n));
    for (int i = 0; i < got_q.size() && i < n; i++)
      chk($sformatf("%s_data%0d", nm, i), got_q[i], line(base + i));
  endtask

  initial begin
    rst = 1; rd_go = 0; rd_en = 0; wr_go = 0; wr_en = 0;
    rd_addr = '0; wr_addr = '0; cache_lines = '0; wr_size = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_empty", 512'(empty), 512'(1));
    chk("rst_full", 512'(full), 512'(1));
    chk("rst_rd_data", rd_data, '0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 10; i++) tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,0,0,0));
    // write 4 lines of A0..A3 to line 0, wr_en held high throughout
    tbl.push_back(v(0,0,0,0, 1,0,4,1,'hEE, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,1,'hA0, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,1,'hA1, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,1,'hA2, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,1,'hA3, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,1,'hEF, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0,    1,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0,    1,1,0,1,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0,    1,1,0,0,0));
    // read 4 lines from line 0; a second rd_go during the wait is ignored
    tbl.push_back(v(1,0,4,0, 0,0,0,0,0, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,0,0,0));
    tbl.push_back(v(1,7,2,0, 0,0,0,0,0, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0, 0,1,0,0,'hA0));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0, 0,1,0,0,'hA1));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0, 0,1,0,0,'hA2));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0, 0,1,0,0,'hA3));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,1,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,0,0,0));
    // zero-length read and write started together
    tbl.push_back(v(1,9,0,0, 1,9,0,0,0, 1,1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,1,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,0,1,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 1,1,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      exp_d = tbl[i].e_empty ? '0 : line(tbl[i].e_data);
      chk($sformatf("t%0d_empty", i),   512'(empty),   512'(tbl[i].e_empty));
      chk($sformatf("t%0d_full", i),    512'(full),    512'(tbl[i].e_full));
      chk($sformatf("t%0d_rd_done", i), 512'(rd_done), 512'(tbl[i].e_rd_done));
      chk($sformatf("t%0d_wr_done", i), 512'(wr_done), 512'(tbl[i].e_wr_done));
      chk($sformatf("t%0d_rd_data", i), rd_data, exp_d);
      rd_go = tbl[i].rd_go; rd_addr = addr(tbl[i].rd_line);
      cache_lines = 16'(tbl[i].rd_len); rd_en = tbl[i].rd_en;
      wr_go = tbl[i].wr_go; wr_addr = addr(tbl[i].wr_line);
      wr_size = 16'(tbl[i].wr_len); wr_en = tbl[i].wr_en; wr_data = line(tbl[i].wr_val);
    end

    // wrapping write: lines 254,255,0..5 get B0..B7
    run_bursts(1, 254, 8, 'hB0, 0, 0, 0, 60);
    chk("wrap_wr_acc", 512'(acc_n), 512'(8));
    chk("wrap_wr_done_n", 512'(wr_done_n), 512'(1));
    chk("wrap_rd_done_n", 512'(rd_done_n), 512'(0));

    // wrapping read with rd_en low for 10 cycles
    @(negedge clk);
    chk("stall_empty_c0", 512'(empty), 512'(1));
    rd_go = 1; rd_addr = addr(254); cache_lines = 16'd8; rd_en = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      rd_go = 0;
      chk($sformatf("stall_empty_c%0d", c), 512'(empty), 512'(c < 4));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("stall_empty_p%0d", i), 512'(empty), 512'(0));
      chk($sformatf("stall_data_p%0d", i), rd_data, line('hB0 + i));
      chk($sformatf("stall_rd_done_p%0d", i), 512'(rd_done), 512'(0));
      rd_en = 1;
    end
    @(negedge clk);
    rd_en = 0;
    chk("stall_rd_done", 512'(rd_done), 512'(1));
    @(negedge clk);
    chk("stall_rd_done_end", 512'(rd_done), 512'(0));
    chk("stall_empty_end", 512'(empty), 512'(1));

    // concurrent write (lines 100..102) and read (lines 0..3)
    run_bursts(1, 100, 3, 'hC0, 1, 0, 4, 60);
    chk("conc_wr_acc", 512'(acc_n), 512'(3));
    chk("conc_wr_done_n", 512'(wr_done_n), 512'(1));
    chk("conc_rd_done_n", 512'(rd_done_n), 512'(1));
    chk_reads("conc_rd", 4, 'hB2);
    run_bursts(0, 0, 0, 0, 1, 100, 3, 60);
    chk("conc_back_done_n", 512'(rd_done_n), 512'(1));
    chk_reads("conc_back", 3, 'hC0);

    // reset in the middle of a read after two pops
    @(negedge clk);
    rd_go = 1; rd_addr = addr(0); cache_lines = 16'd4; pops = 0;
    for (int c = 0; c < 20 && pops < 2; c++) begin
      @(negedge clk);
      rd_go = 0;
      rd_en = !empty;
      if (rd_en) pops++;
    end
    chk("rst_mid_pops", 512'(pops), 512'(2));
    @(negedge clk);
    rd_en = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_empty", 512'(empty), 512'(1));
    chk("rst_mid_full", 512'(full), 512'(1));
    chk("rst_mid_rd_data", rd_data, '0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_mid_no_done%0d", c), 512'(rd_done), 512'(0));
      @(negedge clk);
    end
    run_bursts(0, 0, 0, 0, 1, 0, 4, 60);
    chk("reread_done_n", 512'(rd_done_n), 512'(1));
    chk_reads("reread", 4, 'hB2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
